// File: rtl/bf16_lane_serializer.sv
// bf16_lane_serializer: buffers one packed BF16 vector and emits it one lane per valid/ready beat.
// Optional macro BF16_FTZ_EN flushes subnormal lanes to signed zero on the output and adds ftz_flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | buffer empty, in_ready=1, out_valid=0
// SEND  | presenting buffer lane out_lane; next vector accepted on last beat
module bf16_lane_serializer #(
   parameter int N = 2,
   localparam int LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk1,
   input  logic            rst1_n,
   input  logic [16*N-1:0] in_vec,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [15:0]     out_data,
   output logic [LW-1:0]   out_lane,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_last,
`ifdef BF16_FTZ_EN
   output logic            ftz_flag,
`endif
   output logic [7:0]      vec_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [LW-1:0] LAST_IDX = LW'(N - 1);

   state_t          state;
   logic [16*N-1:0] buffer;
   logic [15:0]     lane_raw;
   logic [LW-1:0]   idx_next;
   logic            beat;
   logic            accept;

   function automatic logic [15:0] lane_of(input logic [16*N-1:0] v, input logic [LW-1:0] k);
      return v[16*int'(k) +: 16];
   endfunction

   assign beat     = out_valid & out_ready;
   assign in_ready = (state == IDLE) | ((state == SEND) & out_last & out_ready);
   assign accept   = in_valid & in_ready;
   assign idx_next = out_lane + LW'(1);

   // An accept while in SEND can only happen on the last beat, so it also completes a vector.
   always_ff @(posedge clk1 or negedge rst1_n) begin
      if (!rst1_n) begin
         state     <= IDLE;
         buffer    <= '0;
         lane_raw  <= '0;
         out_lane  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         vec_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  buffer    <= in_vec;
                  lane_raw  <= in_vec[15:0];
                  out_lane  <= '0;
                  out_valid <= 1'b1;
                  out_last  <= (N == 1);
                  state     <= SEND;
               end
            end
            SEND: begin
               if (accept) begin
                  vec_cnt   <= vec_cnt + 8'd1;
                  buffer    <= in_vec;
                  lane_raw  <= in_vec[15:0];
                  out_lane  <= '0;
                  out_valid <= 1'b1;
                  out_last  <= (N == 1);
                  state     <= SEND;
               end else if (beat) begin
                  if (out_last) begin
                     vec_cnt   <= vec_cnt + 8'd1;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     out_lane <= idx_next;
                     lane_raw <= lane_of(buffer, idx_next);
                     out_last <= (idx_next == LAST_IDX);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BF16_FTZ_EN
   logic subnormal;

   // Flush happens after the buffer so the stored vector stays bit-exact.
   assign subnormal = (lane_raw[14:7] == 8'd0) && (lane_raw[6:0] != 7'd0);
   assign out_data  = subnormal ? {lane_raw[15], 15'b0} : lane_raw;
   assign ftz_flag  = out_valid & subnormal;
`else
   assign out_data = lane_raw;
`endif

endmodule

// File: tb/tb_bf16_lane_serializer.sv
// Testbench for bf16_lane_serializer: random and directed vectors checked through a beat scoreboard.
module tb_bf16_lane_serializer;
   localparam int N  = 2;
   localparam int LW = (N > 1) ? $clog2(N) : 1;

   typedef struct {
      logic [15:0]   data;
      logic [LW-1:0] lane;
      logic          last;
      logic          flag;
   } beat_t;

   logic            clk1 = 1'b0;
   logic            rst1_n;
   logic [16*N-1:0] in_vec;
   logic            in_valid;
   logic            in_ready;
   logic [15:0]     out_data;
   logic [LW-1:0]   out_lane;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;
   logic [7:0]      vec_cnt;
`ifdef BF16_FTZ_EN
   logic            ftz_flag;
`endif

   beat_t      sb_q[$];
   logic [7:0] exp_cnt;
   int         checks   = 0;
   int         failures = 0;
   int         rdy_mode = 0;

   bf16_lane_serializer #(.N(N)) dut (
      .clk1      (clk1),
      .rst1_n    (rst1_n),
      .in_vec    (in_vec),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_lane  (out_lane),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
`ifdef BF16_FTZ_EN
      .ftz_flag  (ftz_flag),
`endif
      .vec_cnt   (vec_cnt)
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Reference: lane k of the vector, flushed to signed zero when subnormal and FTZ is built in.
   task automatic push_expected(input logic [16*N-1:0] v);
      for (int k = 0; k < N; k++) begin
         beat_t b;
         logic [15:0] x;
         x = v[16*k +: 16];
         b.lane = LW'(k);
         b.last = (k == N - 1);
         b.flag = 1'b0;
`ifdef BF16_FTZ_EN
         if (x[14:7] == 8'd0 && x[6:0] != 7'd0) begin
            x = {x[15], 15'b0};
            b.flag = 1'b1;
         end
`endif
         b.data = x;
         sb_q.push_back(b);
      end
   endtask

   task automatic send_vec(input logic [16*N-1:0] v);
      int n;
      bit hs;
      in_vec   = v;
      in_valid = 1'b1;
      n  = 0;
      hs = 1'b0;
      while (!hs && n < 2000) begin
         @(negedge clk1);
         hs = in_ready;
         if (hs) push_expected(v);
         @(posedge clk1);
         #1;
         n++;
      end
      if (!hs) begin
         checks++;
         failures++;
         $display("FAIL send_vec handshake timeout vec=%h", v);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 5000) begin
         @(posedge clk1);
         #1;
         n++;
      end
      if (n >= 5000) begin
         checks++;
         failures++;
         $display("FAIL drain timeout pending=%0d", sb_q.size());
      end
   endtask

   function automatic logic [15:0] rand_lane();
      logic [31:0] r;
      r = $urandom;
      if (r[20:19] == 2'd0) r[14:7] = 8'd0;
      return r[15:0];
   endfunction

   function automatic logic [16*N-1:0] rand_vec();
      logic [16*N-1:0] v;
      for (int k = 0; k < N; k++) v[16*k +: 16] = rand_lane();
      return v;
   endfunction

   // out_ready: 0 = held high, 1 = random, 2 = held low
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk1);
         #1;
         out_ready = (rdy_mode == 1) ? 1'($urandom % 2) : (rdy_mode == 0);
      end
   end

   // Monitor: stream protocol rules plus scoreboard compare on every presented beat.
   initial begin
      logic          prev_v, prev_r, prev_last, prev_hs;
      logic [15:0]   prev_d;
      logic [LW-1:0] prev_l;
      prev_v = 0; prev_r = 0; prev_last = 0; prev_hs = 0; prev_d = '0; prev_l = '0;
      forever begin
         @(negedge clk1);
         if (!rst1_n) begin
            prev_v = 0; prev_r = 0; prev_last = 0; prev_hs = 0;
         end else begin
            chk("vec_cnt", 32'(vec_cnt), 32'(exp_cnt));
            chk("in_ready", 32'(in_ready), 32'(!out_valid || (out_last && out_ready)));
            if (prev_hs || (prev_v && !(prev_r && prev_last)))
               chk("valid_continuity", 32'(out_valid), 32'd1);
            else if (prev_v && prev_r && prev_last)
               chk("valid_drop_after_last", 32'(out_valid), 32'd0);
            if (prev_v && !prev_r && out_valid) begin
               chk("hold_data", 32'(out_data), 32'(prev_d));
               chk("hold_lane", 32'(out_lane), 32'(prev_l));
               chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat data=%h lane=%0d", out_data, out_lane);
               end else begin
                  chk("beat_data", 32'(out_data), 32'(sb_q[0].data));
                  chk("beat_lane", 32'(out_lane), 32'(sb_q[0].lane));
                  chk("beat_last", 32'(out_last), 32'(sb_q[0].last));
`ifdef BF16_FTZ_EN
                  chk("ftz_flag", 32'(ftz_flag), 32'(sb_q[0].flag));
`endif
                  if (out_ready) begin
                     if (sb_q[0].last) exp_cnt = exp_cnt + 8'd1;
                     void'(sb_q.pop_front());
                  end
               end
            end
            prev_v    = out_valid;
            prev_r    = out_ready;
            prev_last = out_last;
            prev_d    = out_data;
            prev_l    = out_lane;
            prev_hs   = in_valid & in_ready;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_cnt  = '0;
      rst1_n   = 1'b0;
      in_valid = 1'b0;
      in_vec   = '0;
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_lane", 32'(out_lane), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk1);
      #2;
      rst1_n = 1'b1;
      @(posedge clk1);
      #1;

      // Single vector, full-rate consumer
      send_vec(32'h4040_4080);
      in_valid = 1'b0;
      @(negedge clk1);
      chk("t1_lane0_data", 32'(out_data), 32'h4080);
      chk("t1_lane0_lane", 32'(out_lane), 32'd0);
      chk("t1_lane0_last", 32'(out_last), 32'd0);
      @(negedge clk1);
      chk("t1_lane1_data", 32'(out_data), 32'h4040);
      chk("t1_lane1_lane", 32'(out_lane), 32'd1);
      chk("t1_lane1_last", 32'(out_last), 32'd1);
      wait_drain();
      chk("t1_vec_cnt", 32'(vec_cnt), 32'd1);

      // Back-to-back vectors with in_valid held
      send_vec(32'hC170_4120);
      send_vec(32'h4040_4080);
      in_valid = 1'b0;
      wait_drain();
      chk("t2_vec_cnt", 32'(vec_cnt), 32'd3);

      // Backpressure on lane 0
      rdy_mode = 2;
      repeat (2) begin @(posedge clk1); #2; end
      send_vec(32'h4040_4080);
      in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk1);
         chk("bp_data", 32'(out_data), 32'h4080);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      rdy_mode = 0;
      wait_drain();
      chk("t3_vec_cnt", 32'(vec_cnt), 32'd4);

      // Async reset after the lane 0 beat
      repeat (2) begin @(posedge clk1); #2; end
      send_vec(32'h4040_4080);
      in_valid = 1'b0;
      @(posedge clk1);
      #2;
      rst1_n = 1'b0;
      #1;
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_vec_cnt", 32'(vec_cnt), 32'd0);
      chk("mrst_out_data", 32'(out_data), 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      sb_q.delete();
      exp_cnt = '0;
      repeat (2) @(posedge clk1);
      #2;
      rst1_n = 1'b1;
      @(posedge clk1);
      #1;

      // 256 vectors back-to-back: counter wraps to zero
      for (int i = 0; i < 256; i++) send_vec(rand_vec());
      in_valid = 1'b0;
      wait_drain();
      chk("wrap_vec_cnt", 32'(vec_cnt), 32'd0);

      // Subnormal lanes
      send_vec(32'h8001_0040);
      in_valid = 1'b0;
      wait_drain();

      // Random traffic with random gaps and random backpressure
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         send_vec(rand_vec());
         if ($urandom % 3 == 0) begin
            in_valid = 1'b0;
            repeat ($urandom % 3) begin @(posedge clk1); #1; end
         end
      end
      in_valid = 1'b0;
      rdy_mode = 0;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
